// File: rtl/wb_commit_arbiter_pkg.sv
// Shared widths, types and helpers for the in-order writeback/commit arbiter.
package wb_commit_arbiter_pkg;

  localparam int unsigned WB_NUM_REQ     = 4;
  localparam int unsigned WB_TAG_WIDTH   = 4;
  localparam int unsigned WB_TIMEOUT     = 255;
  localparam int unsigned WB_CNT_WIDTH   = 8;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned PC_WIDTH       = 32;
  localparam int unsigned INST_WIDTH     = 32;

  typedef logic [WB_TAG_WIDTH-1:0] wb_tag_t;

  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]      rd;
    logic [PC_WIDTH-1:0]       pc;
    logic [INST_WIDTH-1:0]     inst;
  } wb_req_t;

  // x0 is hardwired zero, so a write to it is never a real RF write.
  function automatic logic rd_writes(input wb_req_t r);
    return r.we && (r.addr != '0);
  endfunction

endpackage

// File: rtl/wb_commit_arbiter_tag_match.sv
// Tag compare against next_tag and lowest-index grant; flags duplicate tag holders.
module wb_commit_arbiter_tag_match
  import wb_commit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = WB_NUM_REQ,
  parameter int unsigned TAG_WIDTH = WB_TAG_WIDTH
) (
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag,
  input  logic [TAG_WIDTH-1:0]         next_tag,
  input  logic                         block,
  output logic [NUM_REQ-1:0]           grant_c,
  output logic                         dup_c
);

  logic [NUM_REQ-1:0] hit;
  logic               found;

  always_comb begin
    hit     = '0;
    grant_c = '0;
    dup_c   = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit[i] = req_vld[i] && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] == next_tag);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hit[i]) begin
        if (found) dup_c = 1'b1;
        else grant_c[i] = 1'b1;
        found = 1'b1;
      end
    end
    // Reset or flush suppresses the grant and the duplicate report for the cycle.
    if (block) begin
      grant_c = '0;
      dup_c   = 1'b0;
    end
  end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Shares the RF write port and commit port among execution units, retiring in tag order.
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = WB_NUM_REQ,
  parameter int unsigned TAG_WIDTH = WB_TAG_WIDTH,
  parameter int unsigned TIMEOUT   = WB_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_vld,
  output logic [NUM_REQ-1:0]                req_rdy,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]      req_tag,
  input  logic [NUM_REQ-1:0]                req_rd_we,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_rd_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]      req_rd,
  input  logic [NUM_REQ*PC_WIDTH-1:0]       req_pc,
  input  logic [NUM_REQ*INST_WIDTH-1:0]     req_inst,
  input  logic                              flush,
  input  logic [TAG_WIDTH-1:0]              flush_tag,
  output logic                              rf_rd_we,
  output logic [REG_ADDR_WIDTH-1:0]         rf_rd_addr,
  output logic [REG_WIDTH-1:0]              rf_rd,
  output logic                              commit_vld,
  output logic [PC_WIDTH-1:0]               commit_pc,
  output logic [INST_WIDTH-1:0]             commit_inst,
  output logic [REG_WIDTH-1:0]              commit_rd,
  output logic                              commit_we,
  output logic                              wb_dup_err,
  output logic                              wb_hang_err
);

  localparam int unsigned CNT_WIDTH = WB_CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  logic [TAG_WIDTH-1:0] next_tag;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [NUM_REQ-1:0]   grant_c;
  logic                 dup_c;
  logic                 xfer_c;
  wb_req_t              win_c;

  wb_commit_arbiter_tag_match #(
    .NUM_REQ   (NUM_REQ),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_tag_match (
    .req_vld  (req_vld),
    .req_tag  (req_tag),
    .next_tag (next_tag),
    .block    (rst || flush),
    .grant_c  (grant_c),
    .dup_c    (dup_c)
  );

  assign req_rdy = grant_c;
  assign xfer_c  = |grant_c;

  // Grant is one-hot, so a priority select of the granted lane is a plain mux.
  always_comb begin
    win_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        win_c.we   = req_rd_we[i];
        win_c.addr = req_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        win_c.rd   = req_rd[i*REG_WIDTH +: REG_WIDTH];
        win_c.pc   = req_pc[i*PC_WIDTH +: PC_WIDTH];
        win_c.inst = req_inst[i*INST_WIDTH +: INST_WIDTH];
      end
    end
  end

  // Retire strobes last one cycle; payload holds until the next retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_rd_we    <= 1'b0;
      rf_rd_addr  <= '0;
      rf_rd       <= '0;
      commit_vld  <= 1'b0;
      commit_pc   <= '0;
      commit_inst <= '0;
      commit_rd   <= '0;
      commit_we   <= 1'b0;
    end else begin
      commit_vld <= xfer_c;
      rf_rd_we   <= xfer_c && rd_writes(win_c);
      commit_we  <= xfer_c && rd_writes(win_c);
      if (xfer_c) begin
        rf_rd_addr  <= win_c.addr;
        rf_rd       <= win_c.rd;
        commit_pc   <= win_c.pc;
        commit_inst <= win_c.inst;
        commit_rd   <= win_c.rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag <= '0;
    end else if (flush) begin
      next_tag <= flush_tag;
    end else if (xfer_c) begin
      next_tag <= next_tag + TAG_WIDTH'(1);
    end
  end

  // Stall watchdog: counts cycles where something waits but nothing retires.
  always_ff @(posedge clk) begin
    if (rst || flush || xfer_c) begin
      wait_cnt <= '0;
    end else if ((|req_vld) && (wait_cnt != TIMEOUT_CNT)) begin
      wait_cnt <= wait_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_dup_err  <= 1'b0;
      wb_hang_err <= 1'b0;
    end else begin
      wb_dup_err  <= wb_dup_err | dup_c;
      wb_hang_err <= wb_hang_err | (wait_cnt == TIMEOUT_CNT);
    end
  end

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter; retire stream checked against an expected-commit queue.
module tb_wb_commit_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_vld;
  logic [3:0]   req_rdy;
  logic [15:0]  req_tag;
  logic [3:0]   req_rd_we;
  logic [19:0]  req_rd_addr;
  logic [127:0] req_rd;
  logic [127:0] req_pc;
  logic [127:0] req_inst;
  logic         flush;
  logic [3:0]   flush_tag;
  logic         rf_rd_we;
  logic [4:0]   rf_rd_addr;
  logic [31:0]  rf_rd;
  logic         commit_vld;
  logic [31:0]  commit_pc;
  logic [31:0]  commit_inst;
  logic [31:0]  commit_rd;
  logic         commit_we;
  logic         wb_dup_err;
  logic         wb_hang_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rd;
    logic [4:0]  addr;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_commit_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_tag     (req_tag),
    .req_rd_we   (req_rd_we),
    .req_rd_addr (req_rd_addr),
    .req_rd      (req_rd),
    .req_pc      (req_pc),
    .req_inst    (req_inst),
    .flush       (flush),
    .flush_tag   (flush_tag),
    .rf_rd_we    (rf_rd_we),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd       (rf_rd),
    .commit_vld  (commit_vld),
    .commit_pc   (commit_pc),
    .commit_inst (commit_inst),
    .commit_rd   (commit_rd),
    .commit_we   (commit_we),
    .wb_dup_err  (wb_dup_err),
    .wb_hang_err (wb_hang_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every retire must match the oldest outstanding expected commit.
  always @(negedge clk) begin
    if (commit_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got pc 0x%0h expected no commit (t=%0t)", commit_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_pc",   commit_pc,   e.pc);
        chk("commit_inst", commit_inst, e.inst);
        chk("commit_rd",   commit_rd,   e.rd);
        chk("commit_we",   32'(commit_we), 32'(e.we));
        chk("rf_rd_we",    32'(rf_rd_we),  32'(e.we));
        chk("rf_rd_addr",  32'(rf_rd_addr), 32'(e.addr));
        chk("rf_rd",       rf_rd,       e.rd);
      end
    end
  end

  // Present a result on a lane; optionally record it as an expected retire.
  task automatic issue(input int lane, input logic [3:0] tag, input logic we,
                       input logic [4:0] addr, input logic [31:0] data,
                       input logic [31:0] pc, input logic [31:0] inst, input bit push);
    exp_t e;
    req_vld[lane]               = 1'b1;
    req_tag[lane*4 +: 4]        = tag;
    req_rd_we[lane]             = we;
    req_rd_addr[lane*5 +: 5]    = addr;
    req_rd[lane*32 +: 32]       = data;
    req_pc[lane*32 +: 32]       = pc;
    req_inst[lane*32 +: 32]     = inst;
    if (push) begin
      e.pc = pc; e.inst = inst; e.rd = data; e.addr = addr;
      e.we = we && (addr != 5'd0);
      exp_q.push_back(e);
    end
  endtask

  // One clock: optionally check req_rdy, then drop vld on lanes that transferred.
  task automatic tick(input bit chk_rdy, input logic [3:0] exp_rdy, input string nm);
    logic [3:0] x;
    #1;
    if (chk_rdy) chk(nm, 32'(req_rdy), 32'(exp_rdy));
    x = req_vld & req_rdy;
    @(posedge clk);
    @(negedge clk);
    req_vld = req_vld & ~x;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; flush_tag = '0;
    req_vld = '0; req_tag = '0; req_rd_we = '0; req_rd_addr = '0;
    req_rd = '0; req_pc = '0; req_inst = '0;

    // Reset: a matching request must not be granted while rst is high.
    issue(0, 4'd0, 1'b1, 5'd9, 32'hdead, 32'h0, 32'h0, 1'b0);
    tick(1'b1, 4'b0000, "rst_rdy");
    tick(1'b0, 4'b0000, "");
    chk("rst_commit_vld", 32'(commit_vld), 32'd0);
    chk("rst_rf_rd_we",   32'(rf_rd_we),   32'd0);
    chk("rst_rf_rd",      rf_rd,           32'd0);
    chk("rst_commit_pc",  commit_pc,       32'd0);
    chk("rst_dup",        32'(wb_dup_err), 32'd0);
    chk("rst_hang",       32'(wb_hang_err), 32'd0);
    req_vld = '0;
    rst = 1'b0;

    // Single ALU retire with one-cycle latency, then payload hold.
    issue(0, 4'd0, 1'b1, 5'd5, 32'h1234, 32'h100, 32'h00500293, 1'b1);
    tick(1'b1, 4'b0001, "t1_rdy");
    chk("t1_rf_we",   32'(rf_rd_we),   32'd1);
    chk("t1_rf_addr", 32'(rf_rd_addr), 32'd5);
    chk("t1_rf_data", rf_rd,           32'h1234);
    tick(1'b1, 4'b0000, "t1_idle_rdy");
    chk("t1_vld_drop", 32'(commit_vld), 32'd0);
    chk("t1_we_drop",  32'(rf_rd_we),   32'd0);
    chk("t1_hold",     rf_rd,           32'h1234);

    // Out-of-lane order: MDU tag1 retires before ALU tag2.
    issue(1, 4'd1, 1'b1, 5'd6, 32'h2222, 32'h104, 32'h02208033, 1'b1);
    issue(0, 4'd2, 1'b1, 5'd7, 32'h3333, 32'h108, 32'h00700393, 1'b1);
    tick(1'b1, 4'b0010, "t2_rdy_mdu");
    tick(1'b1, 4'b0001, "t2_rdy_alu");
    tick(1'b0, 4'b0000, "");

    // x0 destination: commits but no RF write.
    issue(0, 4'd3, 1'b1, 5'd0, 32'h5555, 32'h10c, 32'h00000013, 1'b1);
    tick(1'b1, 4'b0001, "t3_rdy");
    chk("t3_commit_vld", 32'(commit_vld), 32'd1);
    chk("t3_commit_we",  32'(commit_we),  32'd0);
    chk("t3_rf_we",      32'(rf_rd_we),   32'd0);
    tick(1'b0, 4'b0000, "");

    // 16 back-to-back retires, tags 4..15 then wrap to 0..3.
    for (int k = 0; k < 16; k++) begin
      issue(0, 4'(4 + k), 1'b1, 5'(k + 1), 32'h100 + 32'(k), 32'h2000 + 32'(4 * k),
            32'h13 + 32'(k), 1'b1);
      tick(1'b1, 4'b0001, "t4_rdy");
      chk("t4_vld_run", 32'(commit_vld), 32'd1);
    end
    tick(1'b0, 4'b0000, "");
    chk("t4_vld_end", 32'(commit_vld), 32'd0);

    // Flush: LSU tag3 is dropped, redirected stream resumes at tag7.
    flush = 1'b1; flush_tag = 4'd3;
    tick(1'b0, 4'b0000, "");
    flush_tag = 4'd7;
    issue(2, 4'd3, 1'b1, 5'd8, 32'hbad0, 32'h300, 32'h0, 1'b0);
    tick(1'b1, 4'b0000, "t5_flush_rdy");
    flush = 1'b0;
    issue(2, 4'd7, 1'b1, 5'd9, 32'h7777, 32'h400, 32'h00900493, 1'b1);
    tick(1'b1, 4'b0100, "t5_rdy_lsu");
    tick(1'b0, 4'b0000, "");

    // Hang: CSR tag5 never matches next_tag=2.
    flush = 1'b1; flush_tag = 4'd2;
    tick(1'b0, 4'b0000, "");
    flush = 1'b0;
    issue(3, 4'd5, 1'b1, 5'd10, 32'h5, 32'h500, 32'h0, 1'b0);
    repeat (255) tick(1'b0, 4'b0000, "");
    chk("t6_hang_pre", 32'(wb_hang_err), 32'd0);
    tick(1'b0, 4'b0000, "");
    chk("t6_hang_set", 32'(wb_hang_err), 32'd1);
    chk("t6_dup_pre",  32'(wb_dup_err),  32'd0);

    // Duplicate tag: ALU wins, LSU is left with a stale tag.
    issue(0, 4'd2, 1'b1, 5'd11, 32'haaaa, 32'h600, 32'h00b00593, 1'b1);
    issue(2, 4'd2, 1'b1, 5'd12, 32'hbbbb, 32'h604, 32'h0, 1'b0);
    tick(1'b1, 4'b0001, "t6_dup_rdy");
    chk("t6_dup_set", 32'(wb_dup_err), 32'd1);
    tick(1'b1, 4'b0000, "t6_stale_rdy");
    chk("t6_hang_sticky", 32'(wb_hang_err), 32'd1);

    // rst beats a matching request (LSU now holds next_tag=3).
    rst = 1'b1;
    req_tag[8 +: 4] = 4'd3;
    tick(1'b1, 4'b0000, "rst_wins_rdy");
    rst = 1'b0;
    req_vld = '0;
    chk("rst2_dup",  32'(wb_dup_err),  32'd0);
    chk("rst2_hang", 32'(wb_hang_err), 32'd0);
    chk("rst2_vld",  32'(commit_vld),  32'd0);

    // next_tag restarts at 0 after reset.
    issue(0, 4'd0, 1'b1, 5'd13, 32'hcccc, 32'h700, 32'h00d00693, 1'b1);
    tick(1'b1, 4'b0001, "post_rst_rdy");
    tick(1'b0, 4'b0000, "");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
